// File: rtl/pipeline_control_unit.sv
// Pipeline execution controller: run / single-step / stop sequencing, automatic
// halt on a HALT instruction, and a full register-bank dump that streams one
// word per register to a downstream consumer with ready/valid handshaking.
module pipeline_control_unit #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REGISTER = 5,
  parameter int unsigned NB_COUNTER  = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic                   i_halt_detected,
  input  logic [NB_DATA-1:0]     i_reg_data,
  input  logic                   i_tx_ready,
  output logic                   o_valid,
  output logic [NB_REGISTER-1:0] o_reg_sel,
  output logic                   o_dump_sel_en,
  output logic [NB_DATA-1:0]     o_dump_data,
  output logic                   o_dump_valid,
  output logic                   o_halted,
  output logic                   o_busy,
  output logic [NB_COUNTER-1:0]  o_cycle_count
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StHalted,
    StDumpAddr,
    StDumpSend
  } state_e;

  localparam logic [1:0] CmdStop = 2'b00;
  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdDump = 2'b11;

  localparam logic [NB_REGISTER-1:0] LastReg  = '1;
  localparam logic [NB_REGISTER-1:0] RegOne   = NB_REGISTER'(1);
  localparam logic [NB_COUNTER-1:0]  CountMax = '1;
  localparam logic [NB_COUNTER-1:0]  CountOne = NB_COUNTER'(1);

  state_e                 state_q, state_d;
  state_e                 ret_q, ret_d;
  logic                   valid_q, valid_d;
  logic [NB_REGISTER-1:0] reg_sel_q, reg_sel_d;
  logic                   sel_en_q, sel_en_d;
  logic [NB_DATA-1:0]     dump_data_q, dump_data_d;
  logic                   dump_valid_q, dump_valid_d;
  logic                   halted_q, halted_d;
  logic                   busy_q, busy_d;
  logic [NB_COUNTER-1:0]  count_q, count_d;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    valid_d      = 1'b0;
    reg_sel_d    = reg_sel_q;
    sel_en_d     = sel_en_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    halted_d     = halted_q;

    case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            CmdRun: begin
              state_d = StRun;
              valid_d = 1'b1;
            end
            CmdStep: begin
              state_d = StStep;
              valid_d = 1'b1;
            end
            CmdDump: begin
              state_d   = StDumpAddr;
              ret_d     = StIdle;
              reg_sel_d = '0;
              sel_en_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        // Halt takes priority over a simultaneous STOP.
        if (i_halt_detected) begin
          state_d  = StHalted;
          halted_d = 1'b1;
        end else if (i_cmd_valid && (i_cmd == CmdStop)) begin
          state_d = StIdle;
        end else begin
          valid_d = 1'b1;
        end
      end
      StStep: begin
        if (i_halt_detected) begin
          state_d  = StHalted;
          halted_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StHalted: begin
        if (i_cmd_valid && (i_cmd == CmdDump)) begin
          state_d   = StDumpAddr;
          ret_d     = StHalted;
          reg_sel_d = '0;
          sel_en_d  = 1'b1;
        end
      end
      StDumpAddr: begin
        // Bank read data for reg_sel_q is valid by the end of this cycle.
        dump_data_d  = i_reg_data;
        dump_valid_d = 1'b1;
        state_d      = StDumpSend;
      end
      StDumpSend: begin
        if (i_tx_ready) begin
          dump_valid_d = 1'b0;
          if (reg_sel_q == LastReg) begin
            reg_sel_d = '0;
            sel_en_d  = 1'b0;
            state_d   = ret_q;
          end else begin
            reg_sel_d = reg_sel_q + RegOne;
            state_d   = StDumpAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d  = (state_d == StRun) || (state_d == StStep) ||
              (state_d == StDumpAddr) || (state_d == StDumpSend);
    count_d = (valid_q && (count_q != CountMax)) ? count_q + CountOne : count_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      valid_q      <= 1'b0;
      reg_sel_q    <= '0;
      sel_en_q     <= 1'b0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      busy_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      valid_q      <= valid_d;
      reg_sel_q    <= reg_sel_d;
      sel_en_q     <= sel_en_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      halted_q     <= halted_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_reg_sel     = reg_sel_q;
  assign o_dump_sel_en = sel_en_q;
  assign o_dump_data   = dump_data_q;
  assign o_dump_valid  = dump_valid_q;
  assign o_halted      = halted_q;
  assign o_busy        = busy_q;
  assign o_cycle_count = count_q;

endmodule
